// File: rtl/stack_mem_ctrl_if.sv
// Command, response and data_mem bus bundle for stack_mem_ctrl.
// Ports: cmd_* request, rsp_* reply, mem_* data_mem strobes and read data.
interface stack_mem_ctrl_if #(
    parameter int ABITS = 32,
    parameter int DBITS = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DBITS-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DBITS-1:0] rsp_data;
    logic             rsp_err;
    logic             mem_en;
    logic             mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_din;
    logic [DBITS-1:0] mem_dout;

    // CPU / memory side
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, mem_dout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_din
    );

    // stack controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, mem_dout,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Stack access controller: turns PUSH/POP/PEEK into data_mem strobes.
// Ports: clk, rst (sync high), bus (slave), sp count, full, empty.
module stack_mem_ctrl #(
    parameter int          ABITS     = 32,
    parameter int          DBITS     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000,
    parameter int          ADDR_STEP = 4,
    parameter int          DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_mem_ctrl_if.slave      bus,
    output logic [$clog2(DEPTH):0] sp,
    output logic                 full,
    output logic                 empty
);
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam logic [ABITS-1:0] BASE = ABITS'(BASE_ADDR);
    localparam logic [ABITS-1:0] STEP = ABITS'(ADDR_STEP);
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR, RD, RWAIT, RSP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       op_q;
    logic [DBITS-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [ABITS-1:0] addr_q;
    logic [DBITS-1:0] din_q;
    logic             push_ok;
    logic             rd_ok;

    function automatic logic [ABITS-1:0] slot(input logic [SPW-1:0] idx);
        return BASE + ABITS'(idx) * STEP;
    endfunction

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

    assign push_ok = (bus.cmd_op == OP_PUSH) && !full;
    assign rd_ok   = ((bus.cmd_op == OP_POP) || (bus.cmd_op == OP_PEEK))
                     && !empty;

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    unique case (1'b1)
                        push_ok: state_nx = WR;
                        rd_ok:   state_nx = RD;
                        default: state_nx = RSP;
                    endcase
                end
            end
            WR: begin
                bus.mem_we = 1'b1;
                state_nx   = RSP;
            end
            RD: begin
                bus.mem_en = 1'b1;
                state_nx   = RWAIT;
            end
            RWAIT: state_nx = RSP;
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address and write data are computed at accept time so they sit
    // stable in registers for the whole WR/RD strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q       <= bus.cmd_op;
                        rsp_data_q <= '0;
                        rsp_err_q  <= !(push_ok || rd_ok);
                        if (push_ok) begin
                            addr_q <= slot(sp);
                            din_q  <= bus.cmd_data;
                        end else if (rd_ok) begin
                            addr_q <= slot(sp - SPW'(1));
                        end
                    end
                end
                WR: sp <= sp + SPW'(1);
                RD: if (op_q == OP_POP) sp <= sp - SPW'(1);
                RWAIT: rsp_data_q <= bus.mem_dout;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
- Stack-access initiator for the single-cycle stack CPU. It converts PUSH/POP/PEEK commands into `data_mem` port transactions on `en`, `we`, `addr`, `din` and `dout`.
- It owns the stack pointer and returns popped/peeked words through a valid/ready response channel.
- It sits between the CPU control path and the `data_mem` instance and is the only driver of the `data_mem` ports.

Parameters:
- ABITS, 32, memory address width.
- DBITS, 32, data word width.
- BASE_ADDR, 32'h0000, address of stack slot 0.
- ADDR_STEP, 4, address increment per stack slot.
- DEPTH, 256, maximum number of stack entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00=PUSH, 01=POP, 10=PEEK, 11=reserved (treated as error).
- cmd_data  in  DBITS  word to push.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DBITS  popped/peeked word; 0 for PUSH and error responses.
- rsp_err  out  1  overflow, underflow or reserved op.
- mem_en  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ABITS  memory address.
- mem_din  out  DBITS  memory write data.
- mem_dout  in  DBITS  memory read data, valid the cycle after `mem_en`.
- sp  out  log2(DEPTH)+1  current entry count.
- full  out  1  sp == DEPTH.
- empty  out  1  sp == 0.

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, sp=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - cmd_ready=1 after reset (it follows state), empty=1, full=0.
- `cmd_ready` is 1 only in IDLE. A command is accepted on an edge where cmd_valid & cmd_ready; cmd_op and cmd_data are latched at that edge.
- FSM states: IDLE, WR, RD, RWAIT, RSP.
- IDLE -> WR: PUSH and !full.
- IDLE -> RD: POP or PEEK, and !empty.
- IDLE -> RSP with rsp_err=1: PUSH when full, POP/PEEK when empty, or op 11. No memory strobe is issued and sp is unchanged.
- WR (1 cycle):
  - mem_we=1, mem_en=0, mem_addr=BASE_ADDR+sp*ADDR_STEP, mem_din=latched data.
  - sp increments at the end of WR; next state RSP.
- RD (1 cycle):
  - mem_en=1, mem_we=0, mem_addr=BASE_ADDR+(sp-1)*ADDR_STEP.
  - POP decrements sp at the end of RD; PEEK leaves sp unchanged. Next state RWAIT.
- RWAIT (1 cycle): strobes low; rsp_data captures mem_dout at the end of the cycle; next state RSP.
- RSP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_valid & rsp_ready, then state returns to IDLE.
  - rsp_data=0 for PUSH and error responses.
- Latency, measured from the accept edge (accept cycle = T):
  - PUSH: write strobe in cycle T+1; rsp_valid from T+2.
  - POP/PEEK: read strobe in T+1; data sampled in T+2; rsp_valid from T+3.
  - Error: rsp_valid from T+1.
- Back-to-back: the earliest next accept is the cycle after the response handshake, because IDLE is required.
- mem_en and mem_we are never both 1. Both are 0 in every state except RD and WR respectively. mem_addr and mem_din may hold their last values when strobes are low.
- Address arithmetic is modulo 2^ABITS; sp never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation:
  - takes effect at the next edge; any pending strobe or response is dropped;
  - sp=0; stack contents in memory are not cleared.
- full and empty are combinational from sp.

Test Plan:
- Reset, then PUSH 32'hf123 -> mem_we=1 with addr=0 and din=f123 in T+1 only; rsp_valid at T+2 with rsp_err=0; sp=1, empty=0.
- PUSH 0xA, then PUSH 0xB, then POP -> read strobe at addr=4, rsp_data=0xB at T+3; then PEEK -> addr=0, rsp_data=0xA; sp=1 after both.
- POP on empty stack -> rsp_valid at T+1 with rsp_err=1, rsp_data=0; mem_en and mem_we stay 0; sp stays 0.
- Fill to DEPTH=4 (test override), then PUSH -> rsp_err=1, no mem_we, full=1; then POP returns the 4th pushed word and full=0.
- Hold rsp_ready=0 for 5 cycles after a POP -> rsp_valid and rsp_data are stable, cmd_ready=0, and a cmd_valid issued meanwhile is not accepted.
- Assert rst during the RD cycle of a POP -> next cycle state is IDLE, rsp_valid=0, sp=0, and no further mem_en is issued.
